pattern_match_engine: RTL and testbench

- Parametrised, sequential successor to the single-pattern equality/subset detector.
- Stores N_PAT weight patterns of WIDTH bits and accepts one input sample per valid/ready handshake.
- Scans the stored patterns one per clock in a selectable match mode and returns the winning pattern index, a match flag and an agreement score.
- Sits between the grid-input front end and the perceptron decision stage.

---
 rtl/pm_pkg.sv | 20 ++
 rtl/pm_score.sv | 33 +++
 rtl/pattern_match_engine.sv | 140 ++++++++++++++
 tb/tb_pattern_match_engine.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/pm_pkg.sv
// Shared encodings for the pattern match engine: match modes, FSM states,
// and the score-width helper.
package pm_pkg;

  localparam logic [1:0] MODE_EXACT  = 2'd0;
  localparam logic [1:0] MODE_SUBSET = 2'd1;
  localparam logic [1:0] MODE_THRESH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } pm_state_e;

  // Bits needed to hold an agreement count of 0..width.
  function automatic int calc_score_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/pm_score.sv
// Combinational agreement score (popcount of matching bits) and per-mode
// match decision for one sample/pattern pair.
module pm_score
  import pm_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SCORE_W = 5
) (
  input  logic [WIDTH-1:0]   sample,
  input  logic [WIDTH-1:0]   weight,
  input  logic [1:0]         mode,
  input  logic [SCORE_W-1:0] thresh,
  output logic [SCORE_W-1:0] score,
  output logic               match
);

  always_comb begin
    score = '0;
    for (int i = 0; i < WIDTH; i++) begin
      score = score + SCORE_W'(sample[i] ~^ weight[i]);
    end
  end

  // Reserved mode 3 falls through to exact compare.
  always_comb begin
    case (mode)
      MODE_SUBSET: match = ((sample & weight) == weight);
      MODE_THRESH: match = (score >= thresh);
      default:     match = (sample == weight);
    endcase
  end

endmodule

// File: rtl/pattern_match_engine.sv
// Sequential pattern matcher: scans N_PAT stored weights one per clock.
// Optional teach-by-example update enabled by PATTERN_MATCH_LEARN_EN.
module pattern_match_engine
  import pm_pkg::*;
#(
  parameter  int WIDTH   = 16,
  parameter  int N_PAT   = 4,
  localparam int IDX_W   = (N_PAT > 1) ? $clog2(N_PAT) : 1,
  localparam int SCORE_W = calc_score_w(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_mode,
  input  logic [SCORE_W-1:0] in_thresh,
`ifdef PATTERN_MATCH_LEARN_EN
  input  logic               learn_valid,
  input  logic [IDX_W-1:0]   learn_label,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_match,
  output logic [IDX_W-1:0]   out_idx,
  output logic [SCORE_W-1:0] out_score
);

  pm_state_e                    state_q, state_d;
  logic [N_PAT-1:0][WIDTH-1:0]  weight_q, weight_d;
  logic [IDX_W-1:0]             idx_q, idx_d;
  logic [WIDTH-1:0]             sample_q, sample_d;
  logic [1:0]                   mode_q, mode_d;
  logic [SCORE_W-1:0]           thresh_q, thresh_d;
  logic                         best_match_q, best_match_d;
  logic [IDX_W-1:0]             best_idx_q, best_idx_d;
  logic [SCORE_W-1:0]           best_score_q, best_score_d;

  logic [SCORE_W-1:0]           cur_score;
  logic                         cur_match;

  // One scorer shared across the scan; it always sees the registered weights,
  // so a write landing this cycle is invisible to this cycle's evaluation.
  pm_score #(.WIDTH(WIDTH), .SCORE_W(SCORE_W)) u_score (
    .sample (sample_q),
    .weight (weight_q[idx_q]),
    .mode   (mode_q),
    .thresh (thresh_q),
    .score  (cur_score),
    .match  (cur_match)
  );

  always_comb begin
    state_d      = state_q;
    weight_d     = weight_q;
    idx_d        = idx_q;
    sample_d     = sample_q;
    mode_d       = mode_q;
    thresh_d     = thresh_q;
    best_match_d = best_match_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;

`ifdef PATTERN_MATCH_LEARN_EN
    // Applied before the host write so wr_en wins on a slot collision.
    if (state_q == ST_DONE && out_ready && learn_valid && int'(learn_label) < N_PAT)
      weight_d[learn_label] = sample_q;
`endif
    if (wr_en && int'(wr_idx) < N_PAT)
      weight_d[wr_idx] = wr_data;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sample_d     = in_data;
          mode_d       = in_mode;
          thresh_d     = in_thresh;
          best_match_d = 1'b0;
          best_idx_d   = '0;
          best_score_d = '0;
          idx_d        = '0;
          state_d      = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // First match locks the result; otherwise track strictly-better score.
        if (!best_match_q) begin
          if (cur_match) begin
            best_match_d = 1'b1;
            best_idx_d   = idx_q;
            best_score_d = cur_score;
          end else if (idx_q == '0 || cur_score > best_score_q) begin
            best_idx_d   = idx_q;
            best_score_d = cur_score;
          end
        end
        if (int'(idx_q) == N_PAT - 1) state_d = ST_DONE;
        else                          idx_d   = idx_q + IDX_W'(1);
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      weight_q     <= '0;
      idx_q        <= '0;
      sample_q     <= '0;
      mode_q       <= MODE_EXACT;
      thresh_q     <= '0;
      best_match_q <= 1'b0;
      best_idx_q   <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      weight_q     <= weight_d;
      idx_q        <= idx_d;
      sample_q     <= sample_d;
      mode_q       <= mode_d;
      thresh_q     <= thresh_d;
      best_match_q <= best_match_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_match = best_match_q;
  assign out_idx   = best_idx_q;
  assign out_score = best_score_q;

endmodule

// File: tb/tb_pattern_match_engine.sv
// Directed bench for pattern_match_engine (4 patterns x 16 bits).
module tb_pattern_match_engine;
  localparam int WIDTH   = 16;
  localparam int N_PAT   = 4;
  localparam int IDX_W   = 2;
  localparam int SCORE_W = 5;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wr_en = 1'b0;
  logic [IDX_W-1:0]   wr_idx = '0;
  logic [WIDTH-1:0]   wr_data = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data = '0;
  logic [1:0]         in_mode = '0;
  logic [SCORE_W-1:0] in_thresh = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               out_match;
  logic [IDX_W-1:0]   out_idx;
  logic [SCORE_W-1:0] out_score;
`ifdef PATTERN_MATCH_LEARN_EN
  logic               learn_valid = 1'b0;
  logic [IDX_W-1:0]   learn_label = '0;
`endif

  int n_chk = 0;
  int n_fail = 0;

  pattern_match_engine #(.WIDTH(WIDTH), .N_PAT(N_PAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_thresh(in_thresh),
`ifdef PATTERN_MATCH_LEARN_EN
    .learn_valid(learn_valid), .learn_label(learn_label),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_match(out_match),
    .out_idx(out_idx), .out_score(out_score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [IDX_W-1:0] i, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_idx = i; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Issue one sample, measure latency from the accept edge, check result,
  // then retire it with a one-cycle out_ready pulse.
  task automatic run(input string tag, input logic [WIDTH-1:0] d, input logic [1:0] m,
                     input logic [SCORE_W-1:0] th, input logic exp_m,
                     input logic [IDX_W-1:0] exp_i, input logic [SCORE_W-1:0] exp_s);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 20) begin @(posedge clk); #1; cnt++; end
    in_valid = 1'b1; in_data = d; in_mode = m; in_thresh = th;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    chk({tag, ".lat"},   cnt,       N_PAT);
    chk({tag, ".match"}, out_match, exp_m);
    chk({tag, ".idx"},   out_idx,   exp_i);
    chk({tag, ".score"}, out_score, exp_s);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".retire"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    #1;
    chk("rst.out_valid", out_valid, 0);
    chk("rst.outs", {out_match, out_idx, out_score}, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst.in_ready", in_ready, 1);

    wr(0, 16'hE444);
    run("exact_hit",   16'hE444, 2'd0, 0, 1'b1, 0, 16);
    run("subset",      16'hFC44, 2'd1, 0, 1'b1, 0, 14);
    run("exact_miss",  16'hFC44, 2'd0, 0, 1'b0, 0, 14);
    run("thresh14",    16'h4444, 2'd2, 14, 1'b1, 0, 14);
    run("thresh15",    16'h4444, 2'd2, 15, 1'b0, 0, 14);
    run("mode3_exact", 16'hE444, 2'd3, 0, 1'b1, 0, 16);

    wr(0, 16'h0000); wr(1, 16'hE444); wr(2, 16'hE444); wr(3, 16'hFFFF);
    run("prio_subset", 16'hFFFF, 2'd1, 0, 1'b1, 0, 0);
    run("prio_exact",  16'hE444, 2'd0, 0, 1'b1, 1, 16);
    run("nomatch_tie", 16'hE445, 2'd0, 0, 1'b0, 1, 15);

    // Backpressure: result must hold while out_ready stays low.
    in_valid = 1'b1; in_data = 16'hE444; in_mode = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin @(posedge clk); #1; cnt++; end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.hold", {out_valid, in_ready, out_match, out_idx, out_score}, {1'b1, 1'b0, 1'b1, 2'd1, 5'd16});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.retire", out_valid, 0);

    // Reset mid-scan aborts the sample and clears the weights.
    in_valid = 1'b1; in_data = 16'hFFFF; in_mode = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid.out_valid", out_valid, 0);
    chk("rst_mid.outs", {out_match, out_idx, out_score}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid.in_ready", in_ready, 1);
    run("zero_w_hit",  16'h0000, 2'd0, 0, 1'b1, 0, 16);
    run("zero_w_miss", 16'hFFFF, 2'd0, 0, 1'b0, 0, 0);

`ifdef PATTERN_MATCH_LEARN_EN
    learn_valid = 1'b1; learn_label = 2;
    run("learn_src", 16'h1234, 2'd0, 0, 1'b0, 0, 11);
    learn_valid = 1'b0;
    run("learn_hit", 16'h1234, 2'd0, 0, 1'b1, 2, 16);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
